fmul_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754 single-precision multiplier for the FPU. It is the next generation of the fixed 3-stage multiplier.
- Adds configurable latency.
- Adds a valid/ready handshake with backpressure, a pass-through tag for out-of-order writeback bookkeeping, round-to-nearest-even, and signed zero.
- Sits between the FPU issue logic and the FPU result mux. One result per cycle when not stalled.

---
 rtl/fmul_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single multiplier, LATENCY 2..4, valid/ready.
// Define FMUL_SPECIAL_EN for IEEE handling of exponent-255 inputs (NaN/inf).
module fmul_pipe #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             unf
);

  if (LATENCY < 2 || LATENCY > 4) begin : g_bad_latency
    $error("fmul_pipe: LATENCY must be 2..4");
  end

  typedef struct packed {
    logic       s;
    logic [9:0] e;
    logic       zr;
    logic       nan;
    logic       inf;
  } hdr_t;

  typedef struct packed {
    hdr_t        h;
    logic [23:0] m;
    logic        g;
    logic        r;
    logic        st;
  } pn_t;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
    logic        unf;
  } res_t;

  function automatic logic [47:0] f_sum(
    input logic [35:0] lo,
    input logic [35:0] hi
  );
    return {12'b0, lo} + {hi, 12'b0};
  endfunction

  function automatic pn_t f_norm(
    input hdr_t        h,
    input logic [47:0] p
  );
    pn_t n;
    n   = '0;
    n.h = h;
    if (p[47]) begin
      n.h.e = h.e + 10'd1;
      n.m   = p[47:24];
      n.g   = p[23];
      n.r   = p[22];
      n.st  = |p[21:0];
    end else begin
      n.m   = p[46:23];
      n.g   = p[22];
      n.r   = p[21];
      n.st  = |p[20:0];
    end
    return n;
  endfunction

  function automatic res_t f_round(input pn_t n);
    logic        up;
    logic [24:0] mr;
    logic [9:0]  e;
    res_t        r;
    r  = '0;
    up = n.g & (n.r | n.st | n.m[0]);
    mr = {1'b0, n.m} + {24'b0, up};
    e  = n.h.e + {9'b0, mr[24]};
    if (n.h.nan) begin
      r.y = 32'h7FC0_0000;
    end else if (n.h.inf) begin
      r.y = {n.h.s, 8'hFF, 23'b0};
    end else if (n.h.zr) begin
      r.y = {n.h.s, 31'b0};
    end else if ($signed(e) >= 10'sd255) begin
      r.y   = {n.h.s, 8'hFF, 23'b0};
      r.ovf = 1'b1;
    end else if ($signed(e) <= 10'sd0) begin
      r.y   = {n.h.s, 31'b0};
      r.unf = 1'b1;
    end else begin
      r.y = {n.h.s, e[7:0], mr[22:0]};
    end
    return r;
  endfunction

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [7:0]  e1, e2;
  logic [23:0] ma, mb;
  hdr_t        h_in;
  logic [35:0] pl_in, ph_in;

  assign e1    = x1[30:23];
  assign e2    = x2[30:23];
  assign ma    = {1'b1, x1[22:0]};
  assign mb    = {1'b1, x2[22:0]};
  assign pl_in = ma * mb[11:0];
  assign ph_in = ma * mb[23:12];

`ifdef FMUL_SPECIAL_EN
  logic nan1, nan2, inf1, inf2;
  assign nan1 = (e1 == 8'hFF) && (x1[22:0] != 23'd0);
  assign nan2 = (e2 == 8'hFF) && (x2[22:0] != 23'd0);
  assign inf1 = (e1 == 8'hFF) && (x1[22:0] == 23'd0);
  assign inf2 = (e2 == 8'hFF) && (x2[22:0] == 23'd0);
`endif

  // Unpack: sign, biased exponent sum, zero and special classes.
  always_comb begin
    h_in.s  = x1[31] ^ x2[31];
    h_in.e  = {2'b0, e1} + {2'b0, e2} - 10'd127;
    h_in.zr = (e1 == 8'd0) | (e2 == 8'd0);
`ifdef FMUL_SPECIAL_EN
    h_in.nan = nan1 | nan2 | ((inf1 | inf2) & h_in.zr);
    h_in.inf = inf1 | inf2;
`else
    h_in.nan = 1'b0;
    h_in.inf = 1'b0;
`endif
  end

  logic [LATENCY:1]  v;
  logic [TAG_W-1:0]  tg [LATENCY];
  hdr_t              h1;
  logic [35:0]       pl1, ph1;
  res_t              r_nx;

  // Valid bits shift together; everything freezes on stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v <= '0;
    end else if (!stall) begin
      v <= {v[LATENCY-1:1], in_valid};
    end
  end

  // Tags ride alongside their operation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) tg[i] <= '0;
    end else if (!stall) begin
      tg[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tg[i] <= tg[i-1];
    end
  end

  // Stage 1: header and two 24x12 partial products.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      h1  <= '0;
      pl1 <= '0;
      ph1 <= '0;
    end else if (!stall) begin
      h1  <= h_in;
      pl1 <= pl_in;
      ph1 <= ph_in;
    end
  end

  if (LATENCY == 2) begin : g_l2
    assign r_nx = f_round(f_norm(h1, f_sum(pl1, ph1)));
  end else if (LATENCY == 3) begin : g_l3
    pn_t n2;
    // Middle stage: full product sum and normalise.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        n2 <= '0;
      end else if (!stall) begin
        n2 <= f_norm(h1, f_sum(pl1, ph1));
      end
    end
    assign r_nx = f_round(n2);
  end else begin : g_l4
    hdr_t        h2;
    logic [23:0] slo2;
    logic        c2;
    logic [11:0] lt2;
    logic [23:0] ht2;
    logic [24:0] lo_s;
    logic [47:0] p3;
    pn_t         n3;
    assign lo_s = {1'b0, pl1[23:0]} + {1'b0, ph1[11:0], 12'b0};
    // Lower half of the product sum; carry deferred.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        h2   <= '0;
        slo2 <= '0;
        c2   <= 1'b0;
        lt2  <= '0;
        ht2  <= '0;
      end else if (!stall) begin
        h2   <= h1;
        slo2 <= lo_s[23:0];
        c2   <= lo_s[24];
        lt2  <= pl1[35:24];
        ht2  <= ph1[35:12];
      end
    end
    assign p3 = {ht2 + {12'b0, lt2} + {23'b0, c2}, slo2};
    // Upper half of the sum, then normalise.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        n3 <= '0;
      end else if (!stall) begin
        n3 <= f_norm(h2, p3);
      end
    end
    assign r_nx = f_round(n3);
  end

  // Last stage: round, pack, flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!stall) begin
      y   <= r_nx.y;
      ovf <= r_nx.ovf;
      unf <= r_nx.unf;
    end
  end

  assign out_valid = v[LATENCY];
  assign out_tag   = tg[LATENCY-1];

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe.
// Random and directed operands against an integer-arithmetic reference.
module tb_fmul_pipe;
  parameter int LAT = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic [3:0]  out_tag;
  logic        ovf;
  logic        unf;

  fmul_pipe #(.LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_tag(out_tag), .ovf(ovf), .unf(unf)
  );

  typedef struct {
    logic [31:0] y;
    logic [3:0]  tag;
    logic        ovf;
    logic        unf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   drop_cnt = 0;
  int   n_out = 0;
  bit   rnd_ready = 0;
  bit   prev_stall = 0;
  logic [37:0] prev_o;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Reference: exact integer product, rounded by remainder comparison.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] t);
    exp_t r;
    int ea, eb, e;
    bit s;
    longint unsigned ma, mb, p, q, rem, half;
    int sh;
    r = '{default: 0};
    r.tag = t;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s = a[31] ^ b[31];
`ifdef FMUL_SPECIAL_EN
    begin
      bit an, bn, ai, bi;
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      if (an || bn || (ai && eb == 0) || (bi && ea == 0)) begin
        r.y = 32'h7FC00000;
        return r;
      end
      if (ai || bi) begin
        r.y = {s, 8'hFF, 23'b0};
        return r;
      end
    end
`endif
    if (ea == 0 || eb == 0) begin
      r.y = {s, 31'b0};
      return r;
    end
    ma = 64'(8388608 + a[22:0]);
    mb = 64'(8388608 + b[22:0]);
    p = ma * mb;
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      r.y = {s, 8'hFF, 23'b0};
      r.ovf = 1;
    end else if (e <= 0) begin
      r.y = {s, 31'b0};
      r.unf = 1;
    end else begin
      r.y = {s, e[7:0], q[22:0]};
    end
    return r;
  endfunction

  // Sink: drives out_ready (forced drops, random or always ready).
  always @(negedge clk) begin
    if (drop_cnt > 0) begin
      out_ready = 1'b0;
      drop_cnt--;
    end else if (rnd_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: pops and compares on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rstn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, y, out_tag, ovf, unf},
              {1'b1, prev_o});
      if (out_valid) begin
        if (!out_ready) check("in_ready_stall", in_ready, 0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got y=%h tag=%h want none",
                     y, out_tag);
          end else begin
            e = sb.pop_front();
            n_out++;
            check("result", {y, out_tag, ovf, unf},
                  {e.y, e.tag, e.ovf, e.unf});
            if (e.lat) check("latency", cyc - e.acc, LAT - 1);
          end
        end
        prev_stall = !out_ready;
        prev_o = {y, out_tag, ovf, unf};
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input bit lat,
                       input bit use_e, input logic [31:0] ey,
                       input bit eo, input bit eu);
    exp_t e;
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    in_tag = t;
    #1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    e = model(a, b, t);
    if (use_e) begin
      e.y = ey;
      e.ovf = eo;
      e.unf = eu;
    end
    e.acc = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (LAT + 2) @(posedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] w;
    int pick, ex;
    w = $urandom();
    pick = $urandom_range(0, 9);
    if (pick < 6) ex = $urandom_range(96, 158);
    else if (pick < 8) ex = $urandom_range(0, 255);
    else if (pick == 8) ex = 0;
    else ex = ($urandom_range(0, 1) != 0) ? 1 : 254;
    w[30:23] = ex[7:0];
    if ($urandom_range(0, 3) == 0) w[22:0] = '1;
    return w;
  endfunction

  logic [31:0] da [7] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001,
                          32'h3FFFFFFF, 32'h7F000000, 32'h00800000,
                          32'h80000000};
  logic [31:0] db [7] = '{32'h40000000, 32'h40400000, 32'h3F800001,
                          32'h3FFFFFFF, 32'h7F000000, 32'h00800000,
                          32'h3F800000};
  logic [31:0] dy [7] = '{32'h40400000, 32'hC0C00000, 32'h3F800002,
                          32'h407FFFFE, 32'h7F800000, 32'h00000000,
                          32'h80000000};
  bit do_ [7] = '{0, 0, 0, 0, 1, 0, 0};
  bit du_ [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_tag", out_tag, 0);
    check("rst_flags", {ovf, unf}, 0);
    check("rst_in_ready", in_ready, 1);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++)
      issue(da[i], db[i], 4'(i + 5), 1, 1, dy[i], do_[i], du_[i]);
`ifdef FMUL_SPECIAL_EN
    issue(32'h7F800000, 32'h00000000, 4'd1, 1, 1, 32'h7FC00000, 0, 0);
    issue(32'hFF800000, 32'h40000000, 4'd2, 1, 1, 32'hFF800000, 0, 0);
    issue(32'h7FC00001, 32'h3F800000, 4'd3, 1, 1, 32'h7FC00000, 0, 0);
`endif
    idle();
    drain();

    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      issue(rnd_op(), rnd_op(), 4'(i), 0, 0, '0, 0, 0);
      if (i == 3) drop_cnt = 3;
    end
    idle();
    drain();
    check("bp_count", n_out - n0, 8);

    for (int i = 0; i < 3; i++)
      issue(32'h40000000, 32'h40000000, 4'(i + 9), 0, 0, '0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_y", y, 0);
    @(negedge clk);
    rstn = 1'b1;
    n0 = n_out;
    repeat (10) @(posedge clk);
    check("midrst_no_stale", n_out - n0, 0);
    issue(32'h3FC00000, 32'h40000000, 4'hC, 1, 1, 32'h40400000, 0, 0);
    idle();
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      issue(rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), 0, 0, '0, 0, 0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rnd_ready = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
